// File: rtl/adelie_core_top.sv
// adelie_core_top: multi-cycle RV32I core on a unified synchronous-read memory port.
// Define CORE_TOP_MUL_EN to add the single-cycle MUL (low 32 bits) instruction.
module adelie_core_top #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MEM_OUT,
  output logic [31:0] MEM_IN,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WE
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  state_t state_q, state_d;

  logic [31:0] pc_q, ir_q, rs1_q, rs2_q, res_q, npc_q, ea_q, addr_q;
  logic        wen_q, ld_q;
  logic [31:0] regs_q [32];

  logic [6:0]  opcode, f7;
  logic [4:0]  rd;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, pc_plus4;

  assign opcode   = ir_q[6:0];
  assign rd       = ir_q[11:7];
  assign f3       = ir_q[14:12];
  assign f7       = ir_q[31:25];
  assign imm_i    = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s    = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b    = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u    = {ir_q[31:12], 12'd0};
  assign imm_j    = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign pc_plus4 = pc_q + 32'd4;

  function automatic logic [31:0] alu(input logic [2:0] fn, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (fn)
      3'b000:  r = alt ? a - b : a + b;
      3'b001:  r = a << b[4:0];
      3'b010:  r = {31'd0, $signed(a) < $signed(b)};
      3'b011:  r = {31'd0, a < b};
      3'b100:  r = a ^ b;
      3'b101:  if (alt) r = $unsigned($signed(a) >>> b[4:0]);
               else     r = a >> b[4:0];
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  logic [31:0] ex_res, ex_npc, ex_ea;
  logic        ex_wen, ex_ld, ex_st, ex_halt, take;

  always_comb begin
    ex_res  = '0;
    ex_npc  = pc_plus4;
    ex_ea   = rs1_q + imm_i;
    ex_wen  = 1'b0;
    ex_ld   = 1'b0;
    ex_st   = 1'b0;
    ex_halt = 1'b0;
    take    = 1'b0;
    case (opcode)
      OP_LUI:   begin ex_res = imm_u;         ex_wen = 1'b1; end
      OP_AUIPC: begin ex_res = pc_q + imm_u;  ex_wen = 1'b1; end
      OP_JAL:   begin ex_res = pc_plus4; ex_wen = 1'b1; ex_npc = pc_q + imm_j; end
      OP_JALR:  if (f3 == 3'b000) begin
        ex_res = pc_plus4; ex_wen = 1'b1; ex_npc = ex_ea & ~32'd1;
      end
      OP_BRANCH: begin
        case (f3)
          3'b000:  take = (rs1_q == rs2_q);
          3'b001:  take = (rs1_q != rs2_q);
          3'b100:  take = ($signed(rs1_q) <  $signed(rs2_q));
          3'b101:  take = ($signed(rs1_q) >= $signed(rs2_q));
          3'b110:  take = (rs1_q <  rs2_q);
          3'b111:  take = (rs1_q >= rs2_q);
          default: take = 1'b0;
        endcase
        if (take) ex_npc = pc_q + imm_b;
      end
      OP_LOAD: begin
        ex_ld  = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        ex_wen = ex_ld;
      end
      OP_STORE: begin
        ex_st = (f3 inside {3'b000, 3'b001, 3'b010});
        ex_ea = rs1_q + imm_s;
      end
      OP_IMM: begin
        ex_res = alu(f3, (f3 == 3'b101) && ir_q[30], rs1_q, imm_i);
        ex_wen = 1'b1;
      end
      OP_OP: begin
        if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
          ex_res = alu(f3, f7[5], rs1_q, rs2_q);
          ex_wen = 1'b1;
        end
`ifdef CORE_TOP_MUL_EN
        else if (f7 == 7'b0000001 && f3 == 3'b000) begin
          ex_res = rs1_q * rs2_q;
          ex_wen = 1'b1;
        end
`endif
      end
      OP_SYSTEM: ex_halt = (ir_q[19:7] == '0) && (ir_q[31:20] == 12'd0 || ir_q[31:20] == 12'd1);
      default: ;
    endcase
  end

  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_val, st_we, st_data;

  always_comb begin
    ld_b = MEM_OUT[{ea_q[1:0], 3'b000} +: 8];
    ld_h = MEM_OUT[{ea_q[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  ld_val = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_val = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_val = {24'd0, ld_b};
      3'b101:  ld_val = {16'd0, ld_h};
      default: ld_val = MEM_OUT;
    endcase
    case (f3[1:0])
      2'b00:   begin st_we = 32'h0000_00FF << {ea_q[1:0], 3'b000}; st_data = {4{rs2_q[7:0]}};  end
      2'b01:   begin st_we = 32'h0000_FFFF << {ea_q[1], 4'b0000};  st_data = {2{rs2_q[15:0]}}; end
      default: begin st_we = '1;                                   st_data = rs2_q;            end
    endcase
  end

  // MEM_ADDR outside FETCH/MEM replays the last presented address, so HALT holds it.
  always_comb begin
    state_d  = state_q;
    MEM_ADDR = addr_q;
    MEM_WE   = '0;
    MEM_IN   = '0;
    case (state_q)
      S_FETCH:  begin MEM_ADDR = pc_q; state_d = S_DECODE; end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (ex_halt)              state_d = S_HALT;
        else if (ex_ld || ex_st)  state_d = S_MEM;
        else                      state_d = S_WB;
      end
      S_MEM: begin
        MEM_ADDR = {ea_q[31:2], 2'b00};
        if (ld_q) state_d = S_WB;
        else begin
          MEM_WE  = st_we;
          MEM_IN  = st_data;
          state_d = S_FETCH;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    if (rst) begin
      MEM_ADDR = RESET_PC;
      MEM_WE   = '0;
      MEM_IN   = '0;
      state_d  = S_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    addr_q  <= MEM_ADDR;
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC;
      ir_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      res_q   <= '0;
      ea_q    <= '0;
      wen_q   <= 1'b0;
      ld_q    <= 1'b0;
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        S_DECODE: begin
          ir_q  <= MEM_OUT;
          rs1_q <= regs_q[MEM_OUT[19:15]];
          rs2_q <= regs_q[MEM_OUT[24:20]];
        end
        S_EXEC: begin
          res_q <= ex_res;
          npc_q <= ex_npc;
          ea_q  <= ex_ea;
          wen_q <= ex_wen;
          ld_q  <= ex_ld;
        end
        S_MEM: if (!ld_q) pc_q <= npc_q;
        S_WB: begin
          pc_q <= npc_q;
          if (wen_q && rd != 5'd0) regs_q[rd] <= ld_q ? ld_val : res_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_adelie_core_top.sv
// Self-checking bench for adelie_core_top: directed program, store scoreboard with cycle stamps.
module tb_adelie_core_top;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_out, mem_in, mem_addr, mem_we;

  always #5 clk = ~clk;

  adelie_core_top #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .MEM_OUT(mem_out), .MEM_IN(mem_in),
    .MEM_ADDR(mem_addr), .MEM_WE(mem_we)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] addr;
    logic [31:0] we;
    logic [31:0] data;
  } st_t;

  st_t         exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] init_mem [256];
  logic [31:0] ram [256];
  logic [255:0] written = '0;

  // Synchronous-read memory with bit-masked writes; untouched words read their initial image.
  always @(posedge clk) begin
    logic [7:0]  idx;
    logic [31:0] cur;
    idx = mem_addr[9:2];
    cur = written[idx] ? ram[idx] : init_mem[idx];
    mem_out <= cur;
    if (mem_we != '0) begin
      ram[idx]     <= (cur & ~mem_we) | (mem_in & mem_we);
      written[idx] <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (mem_we !== '0) begin
      st_t got, e;
      got = {32'(cyc), mem_addr, mem_we, mem_in};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL store_unexpected: got cyc=%0d addr=%h we=%h data=%h, required no store",
                 cyc, mem_addr, mem_we, mem_in);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL store: got cyc=%0d addr=%h we=%h data=%h, required cyc=%0d addr=%h we=%h data=%h",
                   got.cyc, got.addr, got.we, got.data, e.cyc, e.addr, e.we, e.data);
        end
      end
    end
  end

  function automatic logic [31:0] enc_i(input int op, input int rd, input int f3, input int rs1, input int imm);
    logic [31:0] m;
    m = imm;
    return {m[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] enc_s(input int f3, input int rs1, input int rs2, input int imm);
    logic [31:0] m;
    m = imm;
    return {m[11:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input int f3, input int rs1, input int rs2, input int imm);
    logic [31:0] m;
    m = imm;
    return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:1], m[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input int op, input int rd, input int imm20);
    logic [31:0] m;
    m = imm20;
    return {m[19:0], 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] enc_j(input int rd, input int imm);
    logic [31:0] m;
    m = imm;
    return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
  endfunction

  task automatic put(input int addr, input logic [31:0] w);
    init_mem[addr / 4] = w;
  endtask

  task automatic push_st(input int c, input logic [31:0] a, input logic [31:0] w, input logic [31:0] d);
    exp_q.push_back({32'(c), a, w, d});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc != n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      checks++;
      failures++;
      $display("FAIL wait_cyc: got cycle %0d required %0d", cyc, n);
    end
  endtask

  logic [31:0] mul_exp;
  int          bad;
  logic [31:0] marker;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 256; i++) init_mem[i] = '0;
    marker = enc_s(2, 0, 0, 'h2FC);
    put('h00, enc_i('h13, 1, 0, 0, 5));
    put('h04, enc_i('h13, 1, 0, 0, -1));
    put('h08, enc_s(2, 0, 1, 'h200));
    put('h0C, enc_i('h13, 2, 0, 0, 'hAB));
    put('h10, enc_s(0, 0, 2, 'h10A));
    put('h14, enc_i('h03, 3, 0, 0, 'h105));
    put('h18, enc_s(2, 0, 3, 'h204));
    put('h1C, enc_i('h13, 4, 0, 0, 2));
    put('h20, enc_j(1, 16));
    put('h24, marker);
    put('h28, marker);
    put('h2C, marker);
    put('h30, enc_s(2, 0, 1, 'h208));
    put('h34, enc_i('h03, 3, 1, 0, 'h106));
    put('h38, enc_s(2, 0, 3, 'h20C));
    put('h3C, enc_i('h03, 3, 4, 0, 'h107));
    put('h40, enc_s(2, 0, 3, 'h210));
    put('h44, enc_i('h13, 4, 0, 4, -1));
    put('h48, enc_s(2, 0, 4, 'h214));
    put('h4C, enc_b(1, 4, 0, -8));
    put('h50, enc_i('h13, 1, 0, 0, 7));
    put('h54, enc_i('h13, 2, 0, 0, 6));
    put('h58, enc_r(1, 2, 1, 0, 6));
    put('h5C, enc_s(2, 0, 6, 'h218));
    put('h60, enc_u('h37, 7, 'h80000));
    put('h64, enc_i('h13, 8, 5, 7, 'h404));
    put('h68, enc_s(2, 0, 8, 'h21C));
    put('h6C, enc_r(0, 1, 7, 2, 9));
    put('h70, enc_s(2, 0, 9, 'h220));
    put('h74, enc_u('h17, 10, 0));
    put('h78, enc_i('h67, 10, 0, 10, 'h11));
    put('h7C, marker);
    put('h80, marker);
    put('h84, enc_s(2, 0, 10, 'h224));
    put('h88, enc_s(1, 0, 1, 'h22A));
    put('h8C, 32'h0010_0073);
    put('h90, marker);
    put('h104, 32'h80FF_7F01);

`ifdef CORE_TOP_MUL_EN
    mul_exp = 32'd42;
`else
    mul_exp = 32'd0;
`endif
    push_st(11,  'h200, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push_st(19,  'h108, 32'h00FF_0000, 32'hABAB_ABAB);
    push_st(28,  'h204, 32'hFFFF_FFFF, 32'h0000_007F);
    push_st(40,  'h208, 32'hFFFF_FFFF, 32'h0000_0024);
    push_st(49,  'h20C, 32'hFFFF_FFFF, 32'hFFFF_80FF);
    push_st(58,  'h210, 32'hFFFF_FFFF, 32'h0000_0080);
    push_st(66,  'h214, 32'hFFFF_FFFF, 32'h0000_0001);
    push_st(78,  'h214, 32'hFFFF_FFFF, 32'h0000_0000);
    push_st(98,  'h218, 32'hFFFF_FFFF, mul_exp);
    push_st(110, 'h21C, 32'hFFFF_FFFF, 32'hF800_0000);
    push_st(118, 'h220, 32'hFFFF_FFFF, 32'h0000_0001);
    push_st(130, 'h224, 32'hFFFF_FFFF, 32'h0000_007C);
    push_st(134, 'h228, 32'hFFFF_0000, 32'h0007_0007);

    @(posedge clk); #1;
    chk("reset_addr", mem_addr, 32'h0);
    chk("reset_we",   mem_we,   32'h0);
    chk("reset_in",   mem_in,   32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("first_fetch_addr", mem_addr, 32'h0);
    chk("first_fetch_we",   mem_we,   32'h0);
    wait_cyc(3);
    chk("addr_hold_c3", mem_addr, 32'h0);
    wait_cyc(4);
    chk("second_fetch_c4", mem_addr, 32'h4);

    wait_cyc(138);
    bad = 0;
    for (int k = 0; k < 22; k++) begin
      if (mem_we !== '0 || mem_addr !== 32'h8C) bad++;
      @(negedge clk);
    end
    chk("halt_quiet_bad_cycles", 32'(bad), 32'd0);
    chk("scoreboard_left", 32'(exp_q.size()), 32'd0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("restart_fetch_addr", mem_addr, 32'h0);
    wait_cyc(10);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_store_we",   mem_we,   32'h0);
    chk("abort_store_addr", mem_addr, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("after_abort_fetch0", mem_addr, 32'h0);
    wait_cyc(4);
    chk("after_abort_fetch4", mem_addr, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adelie_core_top.md
# adelie_core_top

Multi-cycle RV32I integer core with a single unified instruction/data memory port. It is the top of the CPU core: the system memory model or SoC fabric attaches directly to the MEM_* pins. Memory is synchronous-read with 1-cycle latency and bit-masked writes. An optional single-cycle MUL extension is available.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- MEM_OUT  in  32  read data from memory; valid the cycle after MEM_ADDR is presented.
- MEM_IN  out  32  write data to memory, lane-aligned.
- MEM_ADDR  out  32  word-aligned byte address (bits[1:0] always 0).
- MEM_WE  out  32  per-bit write mask; 0 means read.

## Operation
- State: PC, IR, x0..x31 (x0 hardwired 0), FSM. Reset: PC=RESET_PC, x1..x31=0, IR=0, state=FETCH, halted=0.
- FSM states:
  - FETCH: MEM_ADDR=PC, MEM_WE=0.
  - DECODE: IR<=MEM_OUT; rs1/rs2 read.
  - EXEC: ALU, branch compare, effective address (rs1+imm).
  - MEM: loads and stores only.
  - WB: rd write, PC update, then return to FETCH.
- Paths:
  - Stores go MEM->FETCH and update PC in MEM.
  - Loads go EXEC->MEM->WB.
  - All other instructions go EXEC->WB.
- Supported: LUI, AUIPC, JAL, JALR (target bit0 cleared), BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP, FENCE (NOP), EBREAK/ECALL (halt).
- Arithmetic: 32-bit wraparound. Shifts use low 5 bits of shamt/rs2. SLT signed, SLTU unsigned. Immediates sign-extended per RV32I.
- Store lanes (a = addr[1:0]):
  - SW: MEM_WE=FFFFFFFF, MEM_IN=rs2.
  - SH: MEM_WE=0000FFFF<<(16*a[1]), MEM_IN=rs2[15:0] replicated in both halves.
  - SB: MEM_WE=000000FF<<(8*a), MEM_IN=rs2[7:0] replicated ×4.
- Load extraction: in WB, the lane is selected from MEM_OUT by a, then sign- or zero-extended.
- Misalignment: word accesses ignore a. Halfword accesses ignore a[0]. No trap.
- Illegal/unknown opcode: executed as NOP (PC+4, no register write).
- Writes to x0 discarded.
- Halt: EBREAK/ECALL enter HALT. In HALT: MEM_WE=0, MEM_ADDR holds the last value, PC frozen. Only rst exits HALT.

## Timing
- MEM_WE is nonzero only during the MEM state of a store, for exactly 1 cycle.
- MEM_ADDR/MEM_IN/MEM_WE are registered or decoded from state. During and the cycle after reset: MEM_ADDR=RESET_PC, MEM_IN=0, MEM_WE=0.
- Latency (cycles per instruction):
  - Load: 5.
  - Store, ALU, branch, jump, LUI, AUIPC: 4.
  - First fetch address appears the cycle rst deasserts.
- Read data sampled exactly 1 cycle after address (DECODE for fetch, WB for load). No wait states; memory must meet this.
- rst asserted in any state, including MEM with a store pending, aborts the instruction. MEM_WE is forced 0 in that same cycle and state returns to FETCH at the next edge.
- Branch taken: PC<=PC+imm in WB. Not taken: PC+4. JAL/JALR write rd=PC+4. With rd==rs1, JALR uses the old rs1.

## Configuration
- CORE_TOP_MUL_EN defined: OP with funct7=0000001, funct3=000 (MUL) writes the low 32 bits of rs1*rs2 in WB. Latency 4. Other RV32M encodings are NOPs.
- Undefined: that encoding is an illegal instruction, executed as NOP. No multiplier is synthesized.

## Test plan
- Reset: rst high 2 cycles then low. The next cycles show MEM_ADDR=0, MEM_WE=0. The second fetch is at 0x4, exactly 4 cycles later (ADDI x1,x0,5 at 0x0).
- ALU/store: ADDI x1,x0,-1; SW x1,8(x0). Expect MEM_ADDR=8, MEM_WE=FFFFFFFF, MEM_IN=FFFFFFFF for one cycle.
- Byte lanes: x2=0x000000AB; SB x2,6(x0). Expect MEM_ADDR=4, MEM_WE=00FF0000, MEM_IN=ABABABAB.
- Loads: memory word at 4 = 0x80FF7F01.
  - LB from 5: x=0x0000007F.
  - LH from 6: x=0xFFFF80FF.
  - LBU from 7: x=0x00000080.
  - Each load takes 5 cycles.
- Control flow: BNE x1,x0,-8 with x1≠0 loops back. JAL x1,+16 at 0x20 gives x1=0x24 and next fetch at 0x30. EBREAK leaves MEM_WE=0 and no fetches until rst.
- Config: MUL x3,x1,x2 with 7×6. With CORE_TOP_MUL_EN, SW x3 stores 42. Without it, x3 is unchanged (0).
